// File: rtl/pipeline_chroma_keyer.sv
// Three-stage chroma keyer: per-channel |fg - key| against a programmable tolerance,
// producing background, foreground or a 50/50 blend, with a per-frame keyed-pixel count.
module pipeline_chroma_keyer #(
  parameter int unsigned R_W       = 5,
  parameter int unsigned G_W       = 6,
  parameter int unsigned B_W       = 5,
  parameter int unsigned CNT_W     = 20,
  localparam int unsigned PIXEL_W  = R_W + G_W + B_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] bg_pixel_in,
  input  logic [PIXEL_W-1:0] fg_pixel_in,
  input  logic [1:0]         cfg_mode,
  input  logic [PIXEL_W-1:0] cfg_key,
  input  logic [PIXEL_W-1:0] cfg_tol,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic [CNT_W-1:0]   keyed_count
);

  localparam int unsigned G_LSB = B_W;
  localparam int unsigned R_LSB = B_W + G_W;

  typedef enum logic [1:0] {
    ModePassFg = 2'd0,
    ModeHard   = 2'd1,
    ModeSoft   = 2'd2,
    ModePassBg = 2'd3
  } mode_e;

  // Active (shadowed) configuration
  mode_e              mode_q, mode_d;
  logic [PIXEL_W-1:0] key_q, key_d;
  logic [PIXEL_W-1:0] tol_q, tol_d;

  // Stage 1
  logic               s1_valid_q, s1_valid_d;
  logic               s1_tag_q, s1_tag_d;
  mode_e              s1_mode_q, s1_mode_d;
  logic [PIXEL_W-1:0] s1_fg_q, s1_fg_d;
  logic [PIXEL_W-1:0] s1_bg_q, s1_bg_d;
  logic [PIXEL_W-1:0] s1_tol_q, s1_tol_d;
  logic [R_W-1:0]     s1_dr_q, s1_dr_d;
  logic [G_W-1:0]     s1_dg_q, s1_dg_d;
  logic [B_W-1:0]     s1_db_q, s1_db_d;

  // Stage 2
  logic               s2_valid_q, s2_valid_d;
  logic               s2_tag_q, s2_tag_d;
  mode_e              s2_mode_q, s2_mode_d;
  logic [PIXEL_W-1:0] s2_fg_q, s2_fg_d;
  logic [PIXEL_W-1:0] s2_bg_q, s2_bg_d;
  logic               s2_keyed_q, s2_keyed_d;
  logic               s2_band_q, s2_band_d;

  // Stage 3 / status
  logic               out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   keyed_count_q, keyed_count_d;

  logic [R_W-1:0] fg_r, key_r, tol_r;
  logic [G_W-1:0] fg_g, key_g, tol_g;
  logic [B_W-1:0] fg_b, key_b, tol_b;
  logic           near_r, near_g, near_b, wide_r, wide_g, wide_b;
  logic [R_W:0]   sum_r;
  logic [G_W:0]   sum_g;
  logic [B_W:0]   sum_b;
  logic [PIXEL_W-1:0] blend, sel;
  logic           hit;
  logic [CNT_W-1:0] run_inc;

  // Config load and stage 1; the frame_start pixel sees the new config via the _d bypass.
  always_comb begin
    mode_d = mode_q;
    key_d  = key_q;
    tol_d  = tol_q;
    if (frame_start) begin
      mode_d = mode_e'(cfg_mode);
      key_d  = cfg_key;
      tol_d  = cfg_tol;
    end

    fg_r  = fg_pixel_in[R_LSB +: R_W];
    fg_g  = fg_pixel_in[G_LSB +: G_W];
    fg_b  = fg_pixel_in[0 +: B_W];
    key_r = key_d[R_LSB +: R_W];
    key_g = key_d[G_LSB +: G_W];
    key_b = key_d[0 +: B_W];

    s1_valid_d = in_valid;
    s1_tag_d   = frame_start;
    s1_mode_d  = mode_d;
    s1_fg_d    = fg_pixel_in;
    s1_bg_d    = bg_pixel_in;
    s1_tol_d   = tol_d;
    s1_dr_d    = (fg_r >= key_r) ? fg_r - key_r : key_r - fg_r;
    s1_dg_d    = (fg_g >= key_g) ? fg_g - key_g : key_g - fg_g;
    s1_db_d    = (fg_b >= key_b) ? fg_b - key_b : key_b - fg_b;
  end

  // Stage 2: near/edge classification; 2*tol is a left shift into one extra bit.
  always_comb begin
    tol_r = s1_tol_q[R_LSB +: R_W];
    tol_g = s1_tol_q[G_LSB +: G_W];
    tol_b = s1_tol_q[0 +: B_W];

    near_r = s1_dr_q <= tol_r;
    near_g = s1_dg_q <= tol_g;
    near_b = s1_db_q <= tol_b;
    wide_r = {1'b0, s1_dr_q} <= {tol_r, 1'b0};
    wide_g = {1'b0, s1_dg_q} <= {tol_g, 1'b0};
    wide_b = {1'b0, s1_db_q} <= {tol_b, 1'b0};

    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
    s2_mode_d  = s1_mode_q;
    s2_fg_d    = s1_fg_q;
    s2_bg_d    = s1_bg_q;
    s2_keyed_d = near_r & near_g & near_b;
    s2_band_d  = wide_r & wide_g & wide_b & ~s2_keyed_d;
  end

  // Stage 3: output select and keyed-pixel accounting
  always_comb begin
    sum_r = {1'b0, s2_fg_q[R_LSB +: R_W]} + {1'b0, s2_bg_q[R_LSB +: R_W]};
    sum_g = {1'b0, s2_fg_q[G_LSB +: G_W]} + {1'b0, s2_bg_q[G_LSB +: G_W]};
    sum_b = {1'b0, s2_fg_q[0 +: B_W]} + {1'b0, s2_bg_q[0 +: B_W]};
    blend = {sum_r[R_W:1], sum_g[G_W:1], sum_b[B_W:1]};

    sel = s2_fg_q;
    unique case (s2_mode_q)
      ModePassFg: sel = s2_fg_q;
      ModeHard:   sel = s2_keyed_q ? s2_bg_q : s2_fg_q;
      ModeSoft:   sel = s2_keyed_q ? s2_bg_q : (s2_band_q ? blend : s2_fg_q);
      ModePassBg: sel = s2_bg_q;
    endcase

    hit = s2_valid_q && s2_keyed_q && (s2_mode_q == ModeHard || s2_mode_q == ModeSoft);

    out_valid_d = s2_valid_q;
    pixel_d     = s2_valid_q ? sel : pixel_q;

    run_inc       = (run_q == {CNT_W{1'b1}}) ? run_q : run_q + CNT_W'(1);
    run_d         = run_q;
    keyed_count_d = keyed_count_q;
    // The tagged pixel belongs to the new frame, so it seeds the restarted count.
    if (s2_tag_q) begin
      keyed_count_d = run_q;
      run_d         = hit ? CNT_W'(1) : '0;
    end else if (hit) begin
      run_d = run_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= ModeHard;
      key_q         <= {{R_W{1'b0}}, {G_W{1'b1}}, {B_W{1'b0}}};
      tol_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_tag_q      <= 1'b0;
      s1_mode_q     <= ModePassFg;
      s1_fg_q       <= '0;
      s1_bg_q       <= '0;
      s1_tol_q      <= '0;
      s1_dr_q       <= '0;
      s1_dg_q       <= '0;
      s1_db_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_tag_q      <= 1'b0;
      s2_mode_q     <= ModePassFg;
      s2_fg_q       <= '0;
      s2_bg_q       <= '0;
      s2_keyed_q    <= 1'b0;
      s2_band_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      pixel_q       <= '0;
      run_q         <= '0;
      keyed_count_q <= '0;
    end else begin
      mode_q        <= mode_d;
      key_q         <= key_d;
      tol_q         <= tol_d;
      s1_valid_q    <= s1_valid_d;
      s1_tag_q      <= s1_tag_d;
      s1_mode_q     <= s1_mode_d;
      s1_fg_q       <= s1_fg_d;
      s1_bg_q       <= s1_bg_d;
      s1_tol_q      <= s1_tol_d;
      s1_dr_q       <= s1_dr_d;
      s1_dg_q       <= s1_dg_d;
      s1_db_q       <= s1_db_d;
      s2_valid_q    <= s2_valid_d;
      s2_tag_q      <= s2_tag_d;
      s2_mode_q     <= s2_mode_d;
      s2_fg_q       <= s2_fg_d;
      s2_bg_q       <= s2_bg_d;
      s2_keyed_q    <= s2_keyed_d;
      s2_band_q     <= s2_band_d;
      out_valid_q   <= out_valid_d;
      pixel_q       <= pixel_d;
      run_q         <= run_d;
      keyed_count_q <= keyed_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign pixel_out   = pixel_q;
  assign keyed_count = keyed_count_q;

endmodule

// File: doc/pipeline_chroma_keyer.md
Name: pipeline_chroma_keyer

Overview:
Parametrised, pipelined chroma keyer for the compositing pipeline. It replaces the fixed green-threshold key. It compares each foreground pixel against a programmable key colour with per-channel tolerance. Output is background (keyed), foreground, or a 50/50 blend in a soft edge band. Configuration is shadowed and applied only at frame boundaries. The block also counts fully-keyed pixels per frame for software status.

Parameters:
R_W, 5, red channel width (pixel MSBs)
G_W, 6, green channel width (middle bits)
B_W, 5, blue channel width (pixel LSBs)
CNT_W, 20, keyed-pixel counter width
(derived, not overridable: PIXEL_W = R_W+G_W+B_W)

Ports:
clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
frame_start  in  1  one-cycle pulse marking the first pixel slot of a frame
in_valid  in  1  bg_pixel_in/fg_pixel_in valid this cycle
bg_pixel_in  in  PIXEL_W  background pixel {R,G,B}
fg_pixel_in  in  PIXEL_W  foreground pixel {R,G,B}
cfg_mode  in  2  0 = pass fg, 1 = hard key, 2 = soft key, 3 = pass bg
cfg_key  in  PIXEL_W  key colour {R,G,B}
cfg_tol  in  PIXEL_W  per-channel tolerance packed {R,G,B}
out_valid  out  1  pixel_out valid
pixel_out  out  PIXEL_W  composited pixel
keyed_count  out  CNT_W  fully-keyed valid pixels in last completed frame

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- No backpressure; every input slot advances one stage per cycle.

Reset:
- out_valid = 0, pixel_out = 0, keyed_count = 0, internal counter = 0, all pipeline valids/tags = 0.
- Active config resets to key = {0, all-ones, 0} (pure green), tol = 0, mode = 1.

Config shadowing:
- Active mode/key/tol load from cfg_* in the cycle frame_start = 1.
- The pixel presented in that same cycle already uses the new cfg_* values (bypass mux at stage 1).
- cfg_* changes at any other time have no effect.

Pipeline, fixed latency 3 cycles:
- S1: register pixels, in_valid, frame_start tag and mode. Compute per-channel |fg - key| at channel width.
- S2: per channel, compute near = diff <= tol and edge = diff <= 2*tol. 2*tol is computed at channel width + 1; no overflow.
  - keyed = all channels near.
  - band = all channels edge AND NOT keyed.
- S3: select and register pixel_out:
  - mode 0 -> fg.
  - mode 3 -> bg.
  - mode 1 -> keyed ? bg : fg (band ignored).
  - mode 2 -> keyed ? bg : band ? blend : fg.
  - blend per channel = floor((fg + bg) / 2), computed at channel width + 1.
- out_valid(t+3) = in_valid(t).
- pixel_out holds its last value while out_valid = 0.

Counter:
- Increments at S3 when valid AND the selected output is bg because keyed in mode 1/2. Mode 3 does not count.
- When the frame_start tag reaches S3: keyed_count <= running count (frame_start in the same cycle as a count does not double-count).
- Running count restarts at 1 if that S3 pixel counts, else 0.
- The first tag after reset therefore publishes the pixels seen before it.
- Counter saturates at all-ones and does not wrap.

Boundary cases:
- frame_start with in_valid = 0 still loads config and travels as a tag.
- Back-to-back frame_start pulses each publish a count; a frame with no valid pixels publishes 0.
- rst mid-frame flushes the pipeline: no out_valid for 3 cycles after rst deasserts.
- tol = all-ones per channel: every pixel keyed.
- tol = 0: only an exact match is keyed. Soft band is also exact-match only, so band is never set.

Test Plan:
1. Reset, then fg = 0x07E0, bg = 0x1234, in_valid, no frame_start -> pixel_out = 0x1234 at t+3, out_valid exactly 3 cycles after in_valid.
2. frame_start with mode = 2, key = 0x07E0, tol = 0x1082 (R2,G4,B2):
   - fg G = 59 (0x0760) -> bg.
   - fg G = 57 (0x0720), bg = 0xFFFF -> blend 0x7F8F.
   - fg G = 55 (diff 8) -> blend.
   - fg G = 54 (diff 9) -> fg.
3. Same stimulus as 2 in mode 1 -> G = 57/55 pixels pass fg. Mode 0 -> all fg. Mode 3 -> all bg, keyed_count unchanged.
4. Change cfg_mode mid-frame without frame_start -> output unchanged. Pulse frame_start -> the same-cycle pixel uses the new mode.
5. Frame of 100 valid pixels, 37 keyed, then frame_start -> keyed_count = 37 exactly 3 cycles later. Empty frame -> 0.
6. Assert rst with pixels in flight -> out_valid = 0 and pixel_out = 0 the next cycle. Active config returns to green/tol 0/hard.
